// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider for DIV/DIVU/REM/REMU with a start/busy/done handshake.
// One trial subtract per cycle; divide-by-zero and signed overflow resolve in a single cycle.
module seq_divider #(
  parameter int NUM_SIZE = 32
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic                isSigned,
  input  logic [NUM_SIZE-1:0] dIn0,
  input  logic [NUM_SIZE-1:0] dIn1,
  output logic                busy,
  output logic                done,
  output logic [NUM_SIZE-1:0] quotient,
  output logic [NUM_SIZE-1:0] remainder,
  output logic                divByZero,
  output logic                overflow
);

  localparam int CNT_W = $clog2(NUM_SIZE);
  localparam logic [NUM_SIZE-1:0] MOST_NEG = {1'b1, {(NUM_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, DIVIDE, FIX, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [NUM_SIZE-1:0] dividendR;
  logic [NUM_SIZE-1:0] divisorR;
  logic [NUM_SIZE:0]   partRem;
  logic                signedOp;
  logic                qNeg;
  logic                rNeg;

  logic [NUM_SIZE:0]   shifted;
  logic [NUM_SIZE:0]   diff;
  logic                borrow;
  logic                nonNeg;
  logic [NUM_SIZE:0]   nextRem;
  logic [NUM_SIZE-1:0] nextQuo;
  logic [NUM_SIZE-1:0] fixedQuo;
  logic [NUM_SIZE-1:0] fixedRem;

  function automatic logic [NUM_SIZE-1:0] twosNeg(input logic [NUM_SIZE-1:0] x);
    logic signed [NUM_SIZE-1:0] s;
    s = signed'(x);
    return unsigned'(-s);
  endfunction

  // Trial subtract: a set partRem MSB means the shifted window already exceeds any divisor.
  always_comb begin
    shifted  = {partRem[NUM_SIZE-1:0], dividendR[NUM_SIZE-1]};
    {borrow, diff} = {1'b0, shifted} - {2'b0, divisorR};
    nonNeg   = partRem[NUM_SIZE] | ~borrow;
    nextRem  = nonNeg ? diff : shifted;
    nextQuo  = {dividendR[NUM_SIZE-2:0], nonNeg};
    fixedQuo = qNeg ? twosNeg(nextQuo) : nextQuo;
    fixedRem = rNeg ? twosNeg(nextRem[NUM_SIZE-1:0]) : nextRem[NUM_SIZE-1:0];
  end

  // Datapath: operands, magnitudes and partial remainder; never reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          dividendR <= dIn0;
          divisorR  <= dIn1;
          signedOp  <= isSigned;
        end
      end
      PREP: begin
        if (signedOp && dividendR[NUM_SIZE-1]) dividendR <= twosNeg(dividendR);
        if (signedOp && divisorR[NUM_SIZE-1])  divisorR  <= twosNeg(divisorR);
        qNeg    <= signedOp && (dividendR[NUM_SIZE-1] ^ divisorR[NUM_SIZE-1]);
        rNeg    <= signedOp && dividendR[NUM_SIZE-1];
        partRem <= '0;
      end
      DIVIDE, FIX: begin
        partRem   <= nextRem;
        dividendR <= nextQuo;
      end
      default: ;
    endcase
  end

  // Control and registered results. FIX performs the last iteration together with the
  // sign correction, so DIVIDE itself only covers counts NUM_SIZE-1 down to 1.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            divByZero <= 1'b0;
            overflow  <= 1'b0;
            if (dIn1 == '0) begin
              quotient  <= '1;
              remainder <= dIn0;
              divByZero <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else if (isSigned && dIn0 == MOST_NEG && dIn1 == '1) begin
              quotient  <= dIn0;
              remainder <= '0;
              overflow  <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              state <= PREP;
            end
          end
        end
        PREP: begin
          count <= CNT_W'(NUM_SIZE - 1);
          state <= DIVIDE;
        end
        DIVIDE: begin
          count <= count - 1'b1;
          if (count == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          quotient  <= fixedQuo;
          remainder <= fixedRem;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
